message_out_packetiser: RTL and testbench

MESSAGE_OUT_PACKETISER -- requirements
Module: message_out_packetiser

---
 rtl/message_out_packetiser.sv | 125 ++++++++++++
 tb/tb_message_out_packetiser.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/message_out_packetiser.sv
// Assembles a router packet from individually strobed field staging registers and
// queues completed packets in a small FIFO toward the router.
module message_out_packetiser #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int FIFO_DEPTH           = 4,
  parameter int PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                                       + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  output logic                            overflow,
  output logic [15:0]                     packets_sent
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
  logic [MULTICAST_GROUP_BITS-1:0] mc_q, mc_d;
  logic                            done_q, done_d, result_q, result_d;
  logic [MATRIX_TYPE_BITS-1:0]     mtype_q, mtype_d;
  logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
  logic [MATRIX_ELEMENT_BITS-1:0]  elem_q, elem_d;
  logic [PACKET_BITS-1:0]          packet_d;

  logic [PACKET_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;
  logic [15:0]            sent_q;
  logic                   pop, push;

  // Strobed values bypass the staging registers so a same-cycle complete sees them.
  assign x_d      = x_coord_in_valid         ? x_coord_in         : x_q;
  assign y_d      = y_coord_in_valid         ? y_coord_in         : y_q;
  assign mc_d     = multicast_group_in_valid ? multicast_group_in : mc_q;
  assign done_d   = done_flag_in_valid       ? done_flag_in       : done_q;
  assign result_d = result_flag_in_valid     ? result_flag_in     : result_q;
  assign mtype_d  = matrix_type_in_valid     ? matrix_type_in     : mtype_q;
  assign mx_d     = matrix_x_coord_in_valid  ? matrix_x_coord_in  : mx_q;
  assign my_d     = matrix_y_coord_in_valid  ? matrix_y_coord_in  : my_q;
  assign elem_d   = matrix_element_in_valid  ? matrix_element_in  : elem_q;

  assign packet_d = {x_d, y_d, mc_d, done_d, result_d, mtype_d, mx_d, my_d, elem_d};

  assign packet_out_valid  = (count_q != '0);
  assign message_out_ready = (count_q < DEPTH_C);
  assign pop  = packet_out_valid && packet_out_ready;
  assign push = packet_complete_in && ((count_q < DEPTH_C) || pop);

  // Masking with valid keeps the unreset storage invisible while empty or in reset.
  assign packet_out   = packet_out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow     = overflow_q;
  assign packets_sent = sent_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      mc_q       <= '0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
      mtype_q    <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      elem_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sent_q     <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      mc_q     <= mc_d;
      done_q   <= done_d;
      result_q <= result_d;
      mtype_q  <= mtype_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      elem_q   <= elem_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        sent_q   <= sent_q + 16'd1;
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (packet_complete_in && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= packet_d;
  end

endmodule

// File: tb/tb_message_out_packetiser.sv
// Directed bench for message_out_packetiser at default parameters (54-bit packets, depth 4).
module tb_message_out_packetiser;

  localparam int PB = 54;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [0:0]    x_coord_in, y_coord_in, multicast_group_in, matrix_type_in;
  logic          x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid, matrix_type_in_valid;
  logic          done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid;
  logic [7:0]    matrix_x_coord_in, matrix_y_coord_in;
  logic          matrix_x_coord_in_valid, matrix_y_coord_in_valid;
  logic [31:0]   matrix_element_in;
  logic          matrix_element_in_valid;
  logic          packet_complete_in;
  logic          message_out_ready;
  logic [PB-1:0] packet_out;
  logic          packet_out_valid;
  logic          packet_out_ready;
  logic          overflow;
  logic [15:0]   packets_sent;

  int vectors = 0;
  int miscompares = 0;

  message_out_packetiser dut (
    .clk(clk), .reset_n(reset_n),
    .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
    .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
    .multicast_group_in(multicast_group_in), .multicast_group_in_valid(multicast_group_in_valid),
    .done_flag_in(done_flag_in), .done_flag_in_valid(done_flag_in_valid),
    .result_flag_in(result_flag_in), .result_flag_in_valid(result_flag_in_valid),
    .matrix_type_in(matrix_type_in), .matrix_type_in_valid(matrix_type_in_valid),
    .matrix_x_coord_in(matrix_x_coord_in), .matrix_x_coord_in_valid(matrix_x_coord_in_valid),
    .matrix_y_coord_in(matrix_y_coord_in), .matrix_y_coord_in_valid(matrix_y_coord_in_valid),
    .matrix_element_in(matrix_element_in), .matrix_element_in_valid(matrix_element_in_valid),
    .packet_complete_in(packet_complete_in),
    .message_out_ready(message_out_ready),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready),
    .overflow(overflow), .packets_sent(packets_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    x_coord_in_valid = 0; y_coord_in_valid = 0; multicast_group_in_valid = 0;
    done_flag_in_valid = 0; result_flag_in_valid = 0; matrix_type_in_valid = 0;
    matrix_x_coord_in_valid = 0; matrix_y_coord_in_valid = 0; matrix_element_in_valid = 0;
    packet_complete_in = 0;
  endtask

  function automatic logic [63:0] mk(logic x, logic y, logic mc, logic d, logic r, logic t,
                                     logic [7:0] mx, logic [7:0] my, logic [31:0] e);
    return {10'd0, x, y, mc, d, r, t, mx, my, e};
  endfunction

  function automatic logic [63:0] pkt_e(logic [31:0] e);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0, e);
  endfunction

  task automatic push_elem(input logic [31:0] e);
    matrix_element_in = e; matrix_element_in_valid = 1; packet_complete_in = 1;
    tick();
    clr_strobes();
  endtask

  initial begin
    reset_n = 0;
    x_coord_in = 0; y_coord_in = 0; multicast_group_in = 0; matrix_type_in = 0;
    done_flag_in = 0; result_flag_in = 0;
    matrix_x_coord_in = 0; matrix_y_coord_in = 0; matrix_element_in = 0;
    packet_out_ready = 0;
    clr_strobes();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(packet_out_valid), 64'd0);
    chk("rst_ready", 64'(message_out_ready), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_sent", 64'(packets_sent), 64'd0);
    chk("rst_pkt", 64'(packet_out), 64'd0);
    @(negedge clk);
    reset_n = 1;
    tick();

    // single packet through with ready held high
    packet_out_ready = 1;
    x_coord_in = 1; x_coord_in_valid = 1;
    matrix_element_in = 32'hDEADBEEF; matrix_element_in_valid = 1;
    matrix_x_coord_in = 8'd3; matrix_x_coord_in_valid = 1;
    tick();
    clr_strobes();
    chk("idle_valid", 64'(packet_out_valid), 64'd0);
    packet_complete_in = 1;
    tick();
    clr_strobes();
    chk("single_valid", 64'(packet_out_valid), 64'd1);
    chk("single_pkt", 64'(packet_out), 64'h0020_0300_DEAD_BEEF);
    tick();
    chk("single_drain", 64'(packet_out_valid), 64'd0);
    chk("single_sent", 64'(packets_sent), 64'd1);

    // bypass of a same-cycle element strobe
    packet_out_ready = 0;
    push_elem(32'h5);
    chk("bypass_pkt", 64'(packet_out), 64'h0020_0300_0000_0005);
    packet_out_ready = 1;
    tick();
    packet_out_ready = 0;
    chk("bypass_sent", 64'(packets_sent), 64'd2);

    // fill to depth, then push+pop while full
    for (int i = 0; i < 4; i++) push_elem(32'h10 + 32'(i));
    chk("full_ready", 64'(message_out_ready), 64'd0);
    chk("full_ovf", 64'(overflow), 64'd0);
    chk("full_head", 64'(packet_out), pkt_e(32'h10));
    matrix_element_in = 32'h14; matrix_element_in_valid = 1; packet_complete_in = 1;
    packet_out_ready = 1;
    tick();
    clr_strobes();
    packet_out_ready = 0;
    chk("pp_ready", 64'(message_out_ready), 64'd0);
    chk("pp_ovf", 64'(overflow), 64'd0);
    chk("pp_head", 64'(packet_out), pkt_e(32'h11));
    push_elem(32'h15);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(packet_out), pkt_e(32'h11));

    // backpressure, then drain in order
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_pkt", 64'(packet_out), pkt_e(32'h11));
      chk("bp_valid", 64'(packet_out_valid), 64'd1);
    end
    packet_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pkt", 64'(packet_out), pkt_e(32'h11 + 32'(i)));
      tick();
    end
    packet_out_ready = 0;
    chk("drain_valid", 64'(packet_out_valid), 64'd0);
    chk("drain_ready", 64'(message_out_ready), 64'd1);
    chk("drain_sent", 64'(packets_sent), 64'd7);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // all fields, element retained from the dropped push
    y_coord_in = 1; y_coord_in_valid = 1;
    multicast_group_in = 1; multicast_group_in_valid = 1;
    done_flag_in = 1; done_flag_in_valid = 1;
    result_flag_in = 0; result_flag_in_valid = 1;
    matrix_type_in = 1; matrix_type_in_valid = 1;
    matrix_y_coord_in = 8'hA5; matrix_y_coord_in_valid = 1;
    tick();
    clr_strobes();
    packet_complete_in = 1;
    tick();
    clr_strobes();
    chk("layout_pkt", 64'(packet_out), mk(1, 1, 1, 1, 0, 1, 8'd3, 8'hA5, 32'h15));
    result_flag_in = 1; result_flag_in_valid = 1; packet_complete_in = 1;
    tick();
    clr_strobes();
    packet_out_ready = 1;
    tick();
    chk("result_pkt", 64'(packet_out), mk(1, 1, 1, 1, 1, 1, 8'd3, 8'hA5, 32'h15));
    tick();
    packet_out_ready = 0;
    chk("layout_sent", 64'(packets_sent), 64'd9);

    // mid-operation reset with three queued packets
    for (int i = 0; i < 3; i++) push_elem(32'h30 + 32'(i));
    chk("mid_valid", 64'(packet_out_valid), 64'd1);
    chk("mid_ready", 64'(message_out_ready), 64'd1);
    #2;
    reset_n = 0;
    #1;
    chk("mrst_valid", 64'(packet_out_valid), 64'd0);
    chk("mrst_ready", 64'(message_out_ready), 64'd1);
    chk("mrst_sent", 64'(packets_sent), 64'd0);
    chk("mrst_ovf", 64'(overflow), 64'd0);
    chk("mrst_pkt", 64'(packet_out), 64'd0);

    // complete in the very first cycle after release; staging was cleared
    @(negedge clk);
    reset_n = 1;
    push_elem(32'h77);
    chk("first_valid", 64'(packet_out_valid), 64'd1);
    chk("first_pkt", 64'(packet_out), 64'h77);
    packet_out_ready = 1;
    tick();
    chk("first_sent", 64'(packets_sent), 64'd1);
    tick();
    tick();
    chk("idle_pop_sent", 64'(packets_sent), 64'd1);
    chk("idle_pop_valid", 64'(packet_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
